// File: rtl/risc_core_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : risc_core_gen2                                                |
// | Purpose  : Multi-cycle 8-bit-fetch RISC core with bounded HW stack,      |
// |            ready-based IO handshake and trap-cause reporting.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module risc_core_gen2 #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16,
    parameter int STACK_DEPTH = 32,
    parameter int DMEM_AW     = 5,
    parameter int IO_AW       = 16
) (
    input  logic              clk,
    input  logic              async_rst_n,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [7:0]        rom_data,
    output logic [IO_AW-1:0]  io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_wr,
    output logic              io_rd,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ready,
    output logic              halted,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [7:0]        led
);
    localparam int c_sw  = (DATA_W > PC_W) ? DATA_W : PC_W;
    localparam int c_spw = $clog2(STACK_DEPTH + 1);
    localparam int c_siw = $clog2(STACK_DEPTH);

    localparam logic [2:0] c_st_fetch_op   = 3'd0;
    localparam logic [2:0] c_st_fetch_reg  = 3'd1;
    localparam logic [2:0] c_st_fetch_imm1 = 3'd2;
    localparam logic [2:0] c_st_fetch_imm2 = 3'd3;
    localparam logic [2:0] c_st_exec       = 3'd4;
    localparam logic [2:0] c_st_io_wait    = 3'd5;
    localparam logic [2:0] c_st_halt       = 3'd6;

    localparam logic [4:0] c_op_mov = 5'd0,  c_op_add = 5'd1,  c_op_sub = 5'd2,  c_op_mul = 5'd3;
    localparam logic [4:0] c_op_and = 5'd4,  c_op_or  = 5'd5,  c_op_xor = 5'd6,  c_op_not = 5'd7;
    localparam logic [4:0] c_op_rsh = 5'd8,  c_op_lsh = 5'd9,  c_op_cmp = 5'd10, c_op_jgr = 5'd11;
    localparam logic [4:0] c_op_jlt = 5'd12, c_op_jge = 5'd13, c_op_jle = 5'd14, c_op_jeq = 5'd15;
    localparam logic [4:0] c_op_jnq = 5'd16, c_op_jmp = 5'd17, c_op_psh = 5'd18, c_op_pop = 5'd19;
    localparam logic [4:0] c_op_cal = 5'd20, c_op_ret = 5'd21, c_op_lod = 5'd22, c_op_str = 5'd23;
    localparam logic [4:0] c_op_pst = 5'd24, c_op_pld = 5'd25, c_op_hlt = 5'd31;

    logic [2:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [4:0]        r_opcode;
    logic [2:0]        r_dst, r_src1, r_src2;
    logic              r_hasimm1, r_hasimm2;
    logic [7:0]        r_imm1, r_imm2;
    logic              r_gr, r_eq, r_gte;
    logic [c_spw-1:0]  r_sp;
    logic [DATA_W-1:0] r_rf [0:7];
    logic [c_sw-1:0]   r_stack [0:STACK_DEPTH-1];
    logic [DATA_W-1:0] r_dmem [0:(2**DMEM_AW)-1];
    logic [IO_AW-1:0]  r_io_addr;
    logic [DATA_W-1:0] r_io_wdata;
    logic              r_io_wr, r_io_rd, r_halted, r_trap;
    logic [1:0]        r_trap_cause;
    logic [7:0]        r_led;

    logic [DATA_W-1:0] w_src1val, w_src2val, w_dstval, w_rf_val;
    logic              w_rf_we, w_take, w_full, w_empty, w_exec, w_push;
    logic [1:0]        w_fault;
    logic [c_spw-1:0]  w_sp_dec;
    logic [c_sw-1:0]   w_stack_top;

    // r_rf[0] is never written, so register 0 always reads back as zero
    assign w_src1val   = r_hasimm1 ? DATA_W'(r_imm1) : r_rf[r_src1];
    assign w_src2val   = r_hasimm2 ? DATA_W'(r_imm2) : r_rf[r_src2];
    assign w_dstval    = r_rf[r_dst];
    assign w_exec      = (r_state == c_st_exec);
    assign w_full      = (r_sp == c_spw'(STACK_DEPTH));
    assign w_empty     = (r_sp == '0);
    assign w_sp_dec    = r_sp - 1'b1;
    assign w_stack_top = r_stack[w_sp_dec[c_siw-1:0]];
    assign w_push      = w_exec && (r_opcode == c_op_psh || r_opcode == c_op_cal) && !w_full;

    always_comb begin
        w_fault = 2'd0;
        if (w_exec) begin
            if ((r_opcode == c_op_psh || r_opcode == c_op_cal) && w_full)
                w_fault = 2'd1;
            else if ((r_opcode == c_op_pop || r_opcode == c_op_ret) && w_empty)
                w_fault = 2'd2;
            else if (r_opcode > c_op_pld && r_opcode != c_op_hlt)
                w_fault = 2'd3;
        end
    end

    always_comb begin
        w_rf_we  = 1'b1;
        w_rf_val = w_src1val;
        case (r_opcode)
            c_op_mov: w_rf_val = w_src1val;
            c_op_add: w_rf_val = w_src1val + w_src2val;
            c_op_sub: w_rf_val = w_src1val - w_src2val;
            c_op_mul: w_rf_val = w_src1val * w_src2val;
            c_op_and: w_rf_val = w_src1val & w_src2val;
            c_op_or:  w_rf_val = w_src1val | w_src2val;
            c_op_xor: w_rf_val = w_src1val ^ w_src2val;
            c_op_not: w_rf_val = ~w_src1val;
            c_op_rsh: w_rf_val = w_dstval >> 1;
            c_op_lsh: w_rf_val = w_dstval << 1;
            c_op_pop: begin
                w_rf_val = w_stack_top[DATA_W-1:0];
                w_rf_we  = !w_empty;
            end
            c_op_lod: w_rf_val = r_dmem[w_src1val[DMEM_AW-1:0]];
            default:  w_rf_we  = 1'b0;
        endcase
        w_rf_we = w_rf_we && w_exec && (r_dst != 3'd0);
    end

    always_comb begin
        case (r_opcode)
            c_op_jgr: w_take = r_gr;
            c_op_jlt: w_take = !r_gte;
            c_op_jge: w_take = r_gte;
            c_op_jle: w_take = !r_gr;
            c_op_jeq: w_take = r_eq;
            c_op_jnq: w_take = !r_eq;
            c_op_jmp: w_take = 1'b1;
            default:  w_take = 1'b0;
        endcase
    end

    // Storage arrays carry no reset; validity is tracked by SP and program order
    always_ff @(posedge clk) begin
        if (w_push)
            r_stack[r_sp[c_siw-1:0]] <= (r_opcode == c_op_cal) ? c_sw'(r_pc) : c_sw'(w_src1val);
        if (w_exec && r_opcode == c_op_str)
            r_dmem[w_src1val[DMEM_AW-1:0]] <= w_src2val;
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state      <= c_st_fetch_op;
            r_pc         <= '0;
            r_opcode     <= '0;
            r_dst        <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_hasimm1    <= 1'b0;
            r_hasimm2    <= 1'b0;
            r_imm1       <= '0;
            r_imm2       <= '0;
            r_gr         <= 1'b0;
            r_eq         <= 1'b0;
            r_gte        <= 1'b0;
            r_sp         <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
            r_io_addr    <= '0;
            r_io_wdata   <= '0;
            r_io_wr      <= 1'b0;
            r_io_rd      <= 1'b0;
            r_halted     <= 1'b0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'd0;
            r_led        <= '0;
        end else begin
            if (w_rf_we) r_rf[r_dst] <= w_rf_val;
            case (r_state)
                c_st_fetch_op: begin
                    r_opcode <= rom_data[4:0];
                    r_dst    <= rom_data[7:5];
                    r_pc     <= r_pc + 1'b1;
                    r_state  <= c_st_fetch_reg;
                end
                c_st_fetch_reg: begin
                    r_hasimm1 <= rom_data[7];
                    r_hasimm2 <= rom_data[6];
                    r_src1    <= rom_data[5:3];
                    r_src2    <= rom_data[2:0];
                    r_pc      <= r_pc + 1'b1;
                    r_state   <= rom_data[7] ? c_st_fetch_imm1 :
                                 rom_data[6] ? c_st_fetch_imm2 : c_st_exec;
                end
                c_st_fetch_imm1: begin
                    r_imm1  <= rom_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= r_hasimm2 ? c_st_fetch_imm2 : c_st_exec;
                end
                c_st_fetch_imm2: begin
                    r_imm2  <= rom_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    r_state <= c_st_fetch_op;
                    if (w_fault != 2'd0) begin
                        r_halted     <= 1'b1;
                        r_trap       <= 1'b1;
                        r_trap_cause <= w_fault;
                        r_state      <= c_st_halt;
                    end else begin
                        case (r_opcode)
                            c_op_cmp: begin
                                r_gr  <= (w_src1val > w_src2val);
                                r_eq  <= (w_src1val == w_src2val);
                                r_gte <= (w_src1val >= w_src2val);
                            end
                            c_op_psh: r_sp <= r_sp + 1'b1;
                            c_op_pop: r_sp <= w_sp_dec;
                            c_op_cal: begin
                                r_sp <= r_sp + 1'b1;
                                r_pc <= PC_W'(w_src1val);
                            end
                            c_op_ret: begin
                                r_sp <= w_sp_dec;
                                r_pc <= w_stack_top[PC_W-1:0];
                            end
                            c_op_pst, c_op_pld: begin
                                r_io_addr  <= IO_AW'(w_src1val);
                                r_io_wdata <= w_src2val;
                                r_io_wr    <= (r_opcode == c_op_pst);
                                r_io_rd    <= (r_opcode == c_op_pld);
                                r_state    <= c_st_io_wait;
                            end
                            c_op_hlt: begin
                                r_halted <= 1'b1;
                                r_state  <= c_st_halt;
                            end
                            default: if (w_take) r_pc <= PC_W'(w_src1val);
                        endcase
                    end
                end
                c_st_io_wait: begin
                    if (io_ready) begin
                        if (r_io_rd && r_dst != 3'd0) r_rf[r_dst] <= io_rdata;
                        if (r_io_wr) r_led <= w_src2val[7:0];
                        r_io_wr <= 1'b0;
                        r_io_rd <= 1'b0;
                        r_state <= c_st_fetch_op;
                    end
                end
                default: r_state <= c_st_halt;
            endcase
        end
    end

    assign rom_addr   = r_pc;
    assign io_addr    = r_io_addr;
    assign io_wdata   = r_io_wdata;
    assign io_wr      = r_io_wr;
    assign io_rd      = r_io_rd;
    assign halted     = r_halted;
    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;
    assign led        = r_led;
endmodule
`default_nettype wire

// File: tb/tb_risc_core_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_risc_core_gen2                                             |
// | Purpose  : Directed program bench for risc_core_gen2 (STACK_DEPTH = 2).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_risc_core_gen2;
    localparam logic [4:0] OP_MOV = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_MUL = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd6,  OP_NOT = 5'd7,  OP_RSH = 5'd8,  OP_LSH = 5'd9;
    localparam logic [4:0] OP_CMP = 5'd10, OP_JGR = 5'd11, OP_JEQ = 5'd15, OP_PSH = 5'd18;
    localparam logic [4:0] OP_POP = 5'd19, OP_CAL = 5'd20, OP_RET = 5'd21, OP_LOD = 5'd22;
    localparam logic [4:0] OP_STR = 5'd23, OP_PST = 5'd24, OP_PLD = 5'd25, OP_HLT = 5'd31;

    logic        clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] io_addr, io_wdata, io_rdata;
    logic        io_wr, io_rd, io_ready, halted, trap;
    logic [1:0]  trap_cause;
    logic [7:0]  led;
    logic [7:0]  rom [0:255];
    int          p;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr[7:0]];

    risc_core_gen2 #(.DATA_W(16), .PC_W(16), .STACK_DEPTH(2), .DMEM_AW(5), .IO_AW(16)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
        .io_rdata(io_rdata), .io_ready(io_ready), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .led(led)
    );

    task automatic hold_reset();
        async_rst_n = 1'b0;
        io_ready    = 1'b0;
        io_rdata    = 16'h0;
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        p = 0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        async_rst_n = 1'b1;
    endtask

    task automatic ins(input logic [4:0] op, input logic [2:0] d, input logic h1, input logic h2,
                       input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] i1,
                       input logic [7:0] i2);
        rom[p] = {d, op};           p++;
        rom[p] = {h1, h2, s1, s2};  p++;
        if (h1) begin rom[p] = i1; p++; end
        if (h2) begin rom[p] = i2; p++; end
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (halted !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for a strobe, holds io_ready low for 'delay' cycles, then completes it
    task automatic wait_io(input int delay, input logic [15:0] rdata, output logic ok,
                           output logic is_wr, output logic [15:0] addr, output logic [15:0] wdata,
                           output int hi, output logic dropped, output logic [7:0] led0);
        int n = 0;
        hi = 0; dropped = 1'b0; is_wr = 1'b0; addr = 16'h0; wdata = 16'h0; led0 = 8'h0;
        while (!(io_wr || io_rd) && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = io_wr || io_rd;
        if (ok) begin
            is_wr = io_wr; addr = io_addr; wdata = io_wdata; led0 = led;
            repeat (delay) begin
                if (io_wr || io_rd) hi++;
                @(negedge clk);
            end
            io_rdata = rdata;
            io_ready = 1'b1;
            if (io_wr || io_rd) hi++;
            @(negedge clk);
            io_ready = 1'b0;
            dropped = !(io_wr || io_rd);
        end
    endtask

    task automatic test_reset();
        hold_reset();
        vectors++;
        if (rom_addr !== 16'h0 || io_wr !== 1'b0 || io_rd !== 1'b0 || led !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: rom_addr=%h io_wr=%b io_rd=%b led=%h, want 0", rom_addr, io_wr, io_rd, led);
        end
        vectors++;
        if (halted !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_status: halted=%b trap=%b cause=%0d, want 0/0/0", halted, trap, trap_cause);
        end
    endtask

    task automatic test_alu_latency();
        int n;
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        hold_reset();
        ins(OP_MOV, 3'd1, 1, 0, 3'd0, 3'd0, 8'd5, 8'd0);
        ins(OP_ADD, 3'd2, 0, 1, 3'd1, 3'd0, 8'd0, 8'd7);
        ins(OP_HLT, 3'd0, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        release_reset();
        wait_halt(n);
        vectors++;
        if (n !== 11) begin
            miscompares++;
            $display("FAIL alu_latency: cycles=%0d, want 11", n);
        end
        vectors++;
        if (halted !== 1'b1 || trap !== 1'b0) begin
            miscompares++;
            $display("FAIL hlt_status: halted=%b trap=%b, want 1/0", halted, trap);
        end
        hold_reset();
        ins(OP_MOV, 3'd1, 1, 0, 3'd0, 3'd0, 8'd5, 8'd0);
        ins(OP_ADD, 3'd2, 0, 1, 3'd1, 3'd0, 8'd0, 8'd7);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd2, 8'd0, 8'd0);
        release_reset();
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || wr !== 1'b1 || d !== 16'd12) begin
            miscompares++;
            $display("FAIL add_result: ok=%b wr=%b r2=%h, want 000c", ok, wr, d);
        end
    endtask

    task automatic test_mul_wrap();
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        logic [15:0] exp_d [0:1];
        exp_d[0] = 16'hFE01; exp_d[1] = 16'hFC01;
        hold_reset();
        ins(OP_MOV, 3'd1, 1, 0, 3'd0, 3'd0, 8'd255, 8'd0);
        for (int k = 0; k < 2; k++) begin
            ins(OP_MUL, 3'd1, 0, 0, 3'd1, 3'd1, 8'd0, 8'd0);
            ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd1, 8'(k), 8'd0);
        end
        release_reset();
        for (int k = 0; k < 2; k++) begin
            wait_io(1, 16'h0, ok, wr, a, d, hi, dr, l0);
            vectors++;
            if (!ok || a !== 16'(k) || d !== exp_d[k]) begin
                miscompares++;
                $display("FAIL mul_wrap[%0d]: ok=%b addr=%h data=%h, want %h", k, ok, a, d, exp_d[k]);
            end
        end
    endtask

    task automatic test_logic_mem();
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        logic [15:0] exp_d [0:5];
        exp_d[0] = 16'h000F; exp_d[1] = 16'hFF0F; exp_d[2] = 16'h00BE;
        exp_d[3] = 16'hFFFE; exp_d[4] = 16'h0000; exp_d[5] = 16'h7F87;
        hold_reset();
        ins(OP_MOV, 3'd4, 1, 0, 3'd0, 3'd0, 8'hF0, 8'd0);
        ins(OP_XOR, 3'd5, 0, 1, 3'd4, 3'd0, 8'd0, 8'hFF);
        ins(OP_NOT, 3'd6, 0, 0, 3'd4, 3'd0, 8'd0, 8'd0);
        ins(OP_STR, 3'd0, 1, 1, 3'd0, 3'd0, 8'd4, 8'hBE);
        ins(OP_LOD, 3'd2, 1, 0, 3'd0, 3'd0, 8'd4, 8'd0);
        ins(OP_MOV, 3'd3, 1, 0, 3'd0, 3'd0, 8'd1, 8'd0);
        ins(OP_SUB, 3'd3, 0, 0, 3'd0, 3'd3, 8'd0, 8'd0);
        ins(OP_LSH, 3'd3, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        ins(OP_MOV, 3'd0, 1, 0, 3'd0, 3'd0, 8'd9, 8'd0);
        ins(OP_RSH, 3'd6, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd5, 8'd0, 8'd0);
        ins(OP_NOT, 3'd6, 0, 0, 3'd4, 3'd0, 8'd0, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd6, 8'd1, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd2, 8'd2, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd3, 8'd3, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd0, 8'd4, 8'd0);
        ins(OP_RSH, 3'd6, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd6, 8'd5, 8'd0);
        release_reset();
        for (int k = 0; k < 6; k++) begin
            wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
            vectors++;
            if (!ok || a !== 16'(k) || d !== exp_d[k]) begin
                miscompares++;
                $display("FAIL logic_mem[%0d]: ok=%b addr=%h data=%h, want %h", k, ok, a, d, exp_d[k]);
            end
        end
    endtask

    task automatic test_branch();
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        hold_reset();
        ins(OP_CMP, 3'd0, 1, 1, 3'd0, 3'd0, 8'd5, 8'd3);
        ins(OP_JGR, 3'd0, 1, 0, 3'd0, 3'd0, 8'd11, 8'd0);
        ins(OP_PST, 3'd0, 1, 1, 3'd0, 3'd0, 8'd0, 8'd1);
        ins(OP_JEQ, 3'd0, 1, 0, 3'd0, 3'd0, 8'd19, 8'd0);
        ins(OP_PST, 3'd0, 1, 1, 3'd0, 3'd0, 8'd1, 8'd2);
        release_reset();
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || a !== 16'd1 || d !== 16'd2) begin
            miscompares++;
            $display("FAIL branch: ok=%b addr=%h data=%h, want 0001/0002", ok, a, d);
        end
    endtask

    task automatic test_stack();
        int n;
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        hold_reset();
        ins(OP_PSH, 3'd0, 1, 0, 3'd0, 3'd0, 8'h11, 8'd0);
        ins(OP_PSH, 3'd0, 1, 0, 3'd0, 3'd0, 8'h22, 8'd0);
        ins(OP_POP, 3'd1, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        ins(OP_POP, 3'd2, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd1, 8'd0, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd2, 8'd1, 8'd0);
        release_reset();
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || d !== 16'h0022) begin
            miscompares++;
            $display("FAIL stack_lifo0: ok=%b data=%h, want 0022", ok, d);
        end
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || d !== 16'h0011) begin
            miscompares++;
            $display("FAIL stack_lifo1: ok=%b data=%h, want 0011", ok, d);
        end
        hold_reset();
        ins(OP_PSH, 3'd0, 1, 0, 3'd0, 3'd0, 8'd1, 8'd0);
        ins(OP_PSH, 3'd0, 1, 0, 3'd0, 3'd0, 8'd2, 8'd0);
        ins(OP_PSH, 3'd0, 1, 0, 3'd0, 3'd0, 8'd3, 8'd0);
        release_reset();
        wait_halt(n);
        vectors++;
        if (halted !== 1'b1 || trap !== 1'b1 || trap_cause !== 2'd1 || dut.r_sp !== 2'd2) begin
            miscompares++;
            $display("FAIL overflow: halted=%b trap=%b cause=%0d sp=%0d, want 1/1/1/2", halted, trap, trap_cause, dut.r_sp);
        end
        hold_reset();
        ins(OP_POP, 3'd1, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        release_reset();
        wait_halt(n);
        vectors++;
        if (halted !== 1'b1 || trap !== 1'b1 || trap_cause !== 2'd2) begin
            miscompares++;
            $display("FAIL underflow: halted=%b trap=%b cause=%0d, want 1/1/2", halted, trap, trap_cause);
        end
    endtask

    task automatic test_io_wait();
        int n;
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        hold_reset();
        ins(OP_PST, 3'd0, 1, 1, 3'd0, 3'd0, 8'd3, 8'hA5);
        release_reset();
        wait_io(4, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || wr !== 1'b1 || a !== 16'd3 || d !== 16'h00A5 || hi !== 5) begin
            miscompares++;
            $display("FAIL pst_wait: ok=%b wr=%b addr=%h data=%h high=%0d, want 1/1/0003/00a5/5", ok, wr, a, d, hi);
        end
        vectors++;
        if (dr !== 1'b1 || l0 !== 8'h00 || led !== 8'hA5) begin
            miscompares++;
            $display("FAIL pst_led: dropped=%b led_before=%h led_after=%h, want 1/00/a5", dr, l0, led);
        end
        hold_reset();
        ins(OP_PLD, 3'd4, 1, 0, 3'd0, 3'd0, 8'd9, 8'd0);
        ins(OP_PST, 3'd0, 1, 0, 3'd0, 3'd4, 8'd0, 8'd0);
        release_reset();
        wait_io(2, 16'h1234, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || wr !== 1'b0 || a !== 16'd9 || hi !== 3) begin
            miscompares++;
            $display("FAIL pld_req: ok=%b wr=%b addr=%h high=%0d, want 1/0/0009/3", ok, wr, a, hi);
        end
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || d !== 16'h1234) begin
            miscompares++;
            $display("FAIL pld_data: ok=%b r4=%h, want 1234", ok, d);
        end
        hold_reset();
        ins(OP_PLD, 3'd4, 1, 0, 3'd0, 3'd0, 8'd9, 8'd0);
        release_reset();
        n = 0;
        while (io_rd !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 async_rst_n = 1'b0;
        #1;
        vectors++;
        if (io_rd !== 1'b0 || rom_addr !== 16'h0 || n >= 50) begin
            miscompares++;
            $display("FAIL reset_mid_io: io_rd=%b rom_addr=%h waited=%0d, want 0/0000", io_rd, rom_addr, n);
        end
    endtask

    task automatic test_call_illegal();
        int n;
        logic ok, wr, dr; logic [15:0] a, d; int hi; logic [7:0] l0;
        hold_reset();
        ins(OP_CAL, 3'd0, 1, 0, 3'd0, 3'd0, 8'h40, 8'd0);
        ins(OP_PST, 3'd0, 1, 1, 3'd0, 3'd0, 8'd0, 8'h77);
        ins(OP_HLT, 3'd0, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        p = 64;
        ins(OP_PST, 3'd0, 1, 1, 3'd0, 3'd0, 8'd1, 8'h55);
        ins(OP_RET, 3'd0, 0, 0, 3'd0, 3'd0, 8'd0, 8'd0);
        release_reset();
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || a !== 16'd1 || d !== 16'h0055) begin
            miscompares++;
            $display("FAIL call_target: ok=%b addr=%h data=%h, want 0001/0055", ok, a, d);
        end
        wait_io(0, 16'h0, ok, wr, a, d, hi, dr, l0);
        vectors++;
        if (!ok || a !== 16'd0 || d !== 16'h0077) begin
            miscompares++;
            $display("FAIL ret_resume: ok=%b addr=%h data=%h, want 0000/0077", ok, a, d);
        end
        hold_reset();
        rom[0] = 8'h1A;
        rom[1] = 8'h00;
        release_reset();
        wait_halt(n);
        vectors++;
        if (halted !== 1'b1 || trap !== 1'b1 || trap_cause !== 2'd3 || n !== 3) begin
            miscompares++;
            $display("FAIL illegal_op: halted=%b trap=%b cause=%0d cycles=%0d, want 1/1/3/3", halted, trap, trap_cause, n);
        end
    endtask

    initial begin
        test_reset();
        test_alu_latency();
        test_mul_wrap();
        test_logic_mem();
        test_branch();
        test_stack();
        test_io_wait();
        test_call_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
